// File: rtl/m2v_stream_ingress.sv
// MPEG-2 bitstream ingress: byte FIFO between the host stream port and the decoder,
// with inline start-code detection, masked match, interrupt and a 32-bit register slave.
module m2v_stream_ingress #(
    parameter int FIFO_AW = 4,
    parameter int CNT_W   = FIFO_AW + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        control_address,
    input  logic              control_read,
    output logic [31:0]       control_readdata,
    input  logic              control_write,
    input  logic [31:0]       control_writedata,
    output logic              control_readdatavalid,
    output logic              irq,
    input  logic              stream_valid,
    input  logic [7:0]        stream_data,
    output logic              stream_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic              softreset
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] ST_Z0 = 2'd0;
    localparam logic [1:0] ST_Z1 = 2'd1;
    localparam logic [1:0] ST_Z2 = 2'd2;
    localparam logic [1:0] ST_SC = 2'd3;

    logic               enable, irq_en_sc, irq_en_lvl, stop_on_sc;
    logic               sc_hit;
    logic [7:0]         last_sc, sc_value, sc_mask;
    logic [CNT_W-1:0]   thresh, count;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [1:0]         det_state, det_next;
    logic [7:0]         mem [DEPTH];
    logic [31:0]        rd_mux;

    logic push, pop, lvl, sc_match, wr_ctrl, wr_status, sr_req;

    // Handshake: a byte moves on a port only in a cycle where its valid and ready are both high.
    assign stream_ready = enable && (count < FULL_CNT);
    assign out_valid    = (count != '0);
    assign out_data     = out_valid ? mem[rd_ptr] : 8'h00;
    assign push         = stream_valid && stream_ready;
    assign pop          = out_valid && out_ready;
    assign lvl          = (count <= thresh);
    assign wr_ctrl      = control_write && (control_address == 2'd0);
    assign wr_status    = control_write && (control_address == 2'd1);
    assign sr_req       = wr_ctrl && control_writedata[1];
    assign sc_match     = push && (det_state == ST_SC)
                          && (((stream_data ^ sc_value) & sc_mask) == 8'h00);

    always_comb begin
        det_next = det_state;
        if (push) begin
            case (det_state)
                ST_Z0:   det_next = (stream_data == 8'h00) ? ST_Z1 : ST_Z0;
                ST_Z1:   det_next = (stream_data == 8'h00) ? ST_Z2 : ST_Z0;
                ST_Z2:   det_next = (stream_data == 8'h00) ? ST_Z2 :
                                    (stream_data == 8'h01) ? ST_SC : ST_Z0;
                default: det_next = (stream_data == 8'h00) ? ST_Z1 : ST_Z0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !sr_req) mem[wr_ptr] <= stream_data;
    end

    // Softreset has priority over any push/pop issued in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            det_state <= ST_Z0;
        end else if (sr_req) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            det_state <= ST_Z0;
        end else begin
            det_state <= det_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // A softreset write leaves the irq enables and stop_on_sc untouched; a plain host
    // CTRL write beats the hardware enable clear from stop_on_sc.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable     <= 1'b0;
            irq_en_sc  <= 1'b0;
            irq_en_lvl <= 1'b0;
            stop_on_sc <= 1'b0;
            softreset  <= 1'b0;
        end else begin
            softreset <= sr_req;
            if (sr_req) begin
                enable <= 1'b0;
            end else if (wr_ctrl) begin
                enable     <= control_writedata[0];
                irq_en_sc  <= control_writedata[2];
                irq_en_lvl <= control_writedata[3];
                stop_on_sc <= control_writedata[4];
            end else if (sc_match && stop_on_sc) begin
                enable <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sc_hit   <= 1'b0;
            last_sc  <= 8'h00;
            thresh   <= '0;
            sc_value <= 8'h00;
            sc_mask  <= 8'h00;
            irq      <= 1'b0;
        end else begin
            irq <= (sc_hit && irq_en_sc) || (lvl && irq_en_lvl);
            if (sr_req) begin
                sc_hit  <= 1'b0;
                last_sc <= 8'h00;
            end else if (sc_match) begin
                sc_hit  <= 1'b1;
                last_sc <= stream_data;
            end else if (wr_status && control_writedata[0]) begin
                sc_hit <= 1'b0;
            end
            if (control_write && (control_address == 2'd2))
                thresh <= control_writedata[CNT_W-1:0];
            if (control_write && (control_address == 2'd3)) begin
                sc_value <= control_writedata[7:0];
                sc_mask  <= control_writedata[15:8];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (control_address)
            2'd0: rd_mux[4:0] = {stop_on_sc, irq_en_lvl, irq_en_sc, 1'b0, enable};
            2'd1: begin
                rd_mux[0]            = sc_hit;
                rd_mux[1]            = lvl;
                rd_mux[15:8]         = last_sc;
                rd_mux[16 +: CNT_W]  = count;
            end
            2'd2:    rd_mux[CNT_W-1:0] = thresh;
            default: rd_mux[15:0]      = {sc_mask, sc_value};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            control_readdata      <= 32'h0;
            control_readdatavalid <= 1'b0;
        end else begin
            control_readdatavalid <= control_read;
            control_readdata      <= control_read ? rd_mux : 32'h0;
        end
    end
endmodule

// File: tb/tb_m2v_stream_ingress.sv
// Directed bench for m2v_stream_ingress: register table plus FIFO, start-code,
// softreset, read-latency and reset sequences with hand-computed expectations.
module tb_m2v_stream_ingress;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  control_address;
  logic        control_read;
  logic [31:0] control_readdata;
  logic        control_write;
  logic [31:0] control_writedata;
  logic        control_readdatavalid;
  logic        irq;
  logic        stream_valid;
  logic [7:0]  stream_data;
  logic        stream_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        softreset;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } reg_vec_t;

  m2v_stream_ingress dut (
    .clk(clk), .reset_n(reset_n),
    .control_address(control_address), .control_read(control_read),
    .control_readdata(control_readdata), .control_write(control_write),
    .control_writedata(control_writedata), .control_readdatavalid(control_readdatavalid),
    .irq(irq), .stream_valid(stream_valid), .stream_data(stream_data),
    .stream_ready(stream_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .softreset(softreset)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    control_address = a;
    control_writedata = d;
    control_write = 1'b1;
    tick();
    control_write = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    control_address = a;
    control_read = 1'b1;
    tick();
    control_read = 1'b0;
    check("readdatavalid", {31'b0, control_readdatavalid}, 32'd1);
    d = control_readdata;
  endtask

  task automatic push_byte(input logic [7:0] b, input string name);
    stream_valid = 1'b1;
    stream_data = b;
    check(name, {31'b0, stream_ready}, 32'd1);
    tick();
    stream_valid = 1'b0;
  endtask

  initial begin
    reg_vec_t vecs[8];
    logic [31:0] rd;
    logic [7:0] b;
    logic [7:0] seq_a[4];
    logic [7:0] seq_b[5];

    vecs[0] = '{2'd2, 32'hFFFF_FFFF, 32'h0000_001F};
    vecs[1] = '{2'd2, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{2'd3, 32'hABCD_B3B3, 32'h0000_B3B3};
    vecs[3] = '{2'd3, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_001D};
    vecs[5] = '{2'd0, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0002};
    vecs[7] = '{2'd2, 32'h0000_0007, 32'h0000_0007};
    seq_a = '{8'h00, 8'h00, 8'h01, 8'h00};
    seq_b = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hB3};

    // clock/reset
    reset_n = 1'b0;
    control_address = 2'd0; control_read = 1'b0; control_write = 1'b0;
    control_writedata = 32'h0; stream_valid = 1'b0; stream_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst readdata", control_readdata, 32'h0);
    check("rst readdatavalid", {31'b0, control_readdatavalid}, 32'd0);
    check("rst irq", {31'b0, irq}, 32'd0);
    check("rst stream_ready", {31'b0, stream_ready}, 32'd0);
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst out_data", {24'b0, out_data}, 32'd0);
    check("rst softreset", {31'b0, softreset}, 32'd0);
    reset_n = 1'b1;
    tick();

    // register table
    for (int i = 0; i < 8; i++) begin
      reg_write(vecs[i].addr, vecs[i].wdata);
      reg_read(vecs[i].addr, rd);
      check($sformatf("regvec%0d", i), rd, vecs[i].exp_rd);
    end

    // fill to full with level irq enabled, then drain
    reg_write(2'd2, 32'h0);
    reg_write(2'd0, 32'h9);
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i), "fill ready");
    check("full stream_ready", {31'b0, stream_ready}, 32'd0);
    check("full irq", {31'b0, irq}, 32'd0);
    check("full head", {24'b0, out_data}, 32'h10);
    stream_valid = 1'b1; stream_data = 8'hEE;
    tick();
    stream_valid = 1'b0;
    reg_read(2'd1, rd);
    check("full status", rd, 32'h0010_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ready after pop", {31'b0, stream_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check($sformatf("drain%0d", i), {24'b0, out_data}, 32'h10 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("empty out_valid", {31'b0, out_valid}, 32'd0);
    check("lvl irq lag", {31'b0, irq}, 32'd0);
    tick();
    check("lvl irq", {31'b0, irq}, 32'd1);
    reg_write(2'd0, 32'h0);

    // start-code match B3/FF
    reg_write(2'd3, 32'h0000_FFB3);
    reg_write(2'd0, 32'h5);
    for (int i = 0; i < 4; i++) push_byte(seq_a[i], "sc ready a");
    reg_read(2'd1, rd);
    check("sc no hit", rd, 32'h0004_0000);
    for (int i = 0; i < 5; i++) push_byte(seq_b[i], "sc ready b");
    reg_read(2'd1, rd);
    check("sc hit status", rd, 32'h0009_B301);
    check("sc irq", {31'b0, irq}, 32'd1);
    reg_write(2'd1, 32'h1);
    check("sc irq lag", {31'b0, irq}, 32'd1);
    tick();
    check("sc irq cleared", {31'b0, irq}, 32'd0);
    reg_write(2'd0, 32'h2);
    check("sr1 pulse", {31'b0, softreset}, 32'd1);
    check("sr1 out_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("sr1 pulse end", {31'b0, softreset}, 32'd0);

    // stop_on_sc with mask 00
    reg_write(2'd3, 32'h0000_005A);
    reg_write(2'd0, 32'h11);
    for (int i = 0; i < 3; i++) push_byte(seq_a[i], "stop ready");
    push_byte(8'hB8, "stop ready b8");
    check("stop ready low", {31'b0, stream_ready}, 32'd0);
    stream_valid = 1'b1; stream_data = 8'h11;
    tick();
    stream_valid = 1'b0;
    reg_read(2'd1, rd);
    check("stop status", rd, 32'h0004_B801);
    reg_read(2'd0, rd);
    check("stop ctrl", rd, 32'h0000_0010);
    reg_write(2'd0, 32'h11);
    push_byte(8'h11, "reenable ready");
    check("head after stop", {24'b0, out_data}, 32'h00);

    // softreset with 5 bytes buffered and sc_hit set; same-cycle push/pop discarded
    control_address = 2'd0; control_writedata = 32'h2; control_write = 1'b1;
    stream_valid = 1'b1; stream_data = 8'h77; out_ready = 1'b1;
    tick();
    control_write = 1'b0; stream_valid = 1'b0; out_ready = 1'b0;
    check("sr2 pulse", {31'b0, softreset}, 32'd1);
    check("sr2 out_valid", {31'b0, out_valid}, 32'd0);
    check("sr2 stream_ready", {31'b0, stream_ready}, 32'd0);
    tick();
    check("sr2 pulse end", {31'b0, softreset}, 32'd0);
    reg_read(2'd1, rd);
    check("sr2 status", rd, 32'h0000_0002);
    reg_read(2'd3, rd);
    check("sr2 sc_match kept", rd, 32'h0000_005A);

    // flow-through across pointer wrap
    reg_write(2'd0, 32'h1);
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) check($sformatf("flow%0d", i), {24'b0, out_data}, {24'b0, exp_q.pop_front()});
      b = 8'(i * 7 + 3);
      stream_valid = 1'b1; stream_data = b;
      check("flow ready", {31'b0, stream_ready}, 32'd1);
      exp_q.push_back(b);
      tick();
    end
    stream_valid = 1'b0;
    if (out_valid) check("flow last", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
    tick();
    out_ready = 1'b0;
    check("flow drained", {31'b0, out_valid}, 32'd0);
    check("flow all out", 32'(exp_q.size()), 32'd0);
    reg_read(2'd1, rd);
    check("flow status", rd, 32'h0000_0002);

    // back-to-back reads, STATUS read racing a W1C
    reg_write(2'd3, 32'h0000_0042);
    for (int i = 0; i < 3; i++) push_byte(seq_a[i], "rd ready");
    push_byte(8'h42, "rd ready 42");
    control_read = 1'b1;
    control_address = 2'd0;
    tick();
    check("b2b rdv0", {31'b0, control_readdatavalid}, 32'd1);
    check("b2b ctrl", control_readdata, 32'h0000_0001);
    control_address = 2'd1; control_write = 1'b1; control_writedata = 32'h1;
    tick();
    control_write = 1'b0;
    check("b2b rdv1", {31'b0, control_readdatavalid}, 32'd1);
    check("b2b status pre-w1c", control_readdata, 32'h0004_4201);
    control_address = 2'd2;
    tick();
    check("b2b rdv2", {31'b0, control_readdatavalid}, 32'd1);
    check("b2b thresh", control_readdata, 32'h0);
    control_address = 2'd3;
    tick();
    control_read = 1'b0;
    check("b2b rdv3", {31'b0, control_readdatavalid}, 32'd1);
    check("b2b sc_match", control_readdata, 32'h0000_0042);
    tick();
    check("rdv idle", {31'b0, control_readdatavalid}, 32'd0);
    reg_read(2'd1, rd);
    check("w1c cleared", rd, 32'h0004_4200);

    // hardware set beats same-cycle W1C
    for (int i = 0; i < 3; i++) push_byte(seq_a[i], "race ready");
    stream_valid = 1'b1; stream_data = 8'h42;
    control_address = 2'd1; control_write = 1'b1; control_writedata = 32'h1;
    tick();
    stream_valid = 1'b0; control_write = 1'b0;
    reg_read(2'd1, rd);
    check("set wins", rd, 32'h0008_4201);

    // asynchronous reset mid-transfer
    stream_valid = 1'b1; stream_data = 8'h55;
    #2 reset_n = 1'b0;
    #1;
    check("arst out_valid", {31'b0, out_valid}, 32'd0);
    check("arst stream_ready", {31'b0, stream_ready}, 32'd0);
    check("arst irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    stream_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    reg_read(2'd1, rd);
    check("arst status", rd, 32'h0000_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
